// File: rtl/shifter_pkg.sv
// Shared types and constants for the serial shifter family (PISO transmitter, SIPO receiver).
package shifter_pkg;

  localparam int SHIFTER_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} shift_state_t;

  // Wide enough to hold every value from 0 to width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit position counter for the PISO shifter: clear, increment, and a flag on the last data bit.
module piso_bit_cnt
  import shifter_pkg::*;
#(
  parameter int WIDTH = SHIFTER_WIDTH,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          term
);

  assign term = (count == CW'(WIDTH - 1));

  // Saturates at the terminal value so the count can never run past the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc && !term)
      count <= count + CW'(1);
  end

endmodule

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shifter with valid/ready word input and registered serial outputs.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH     = SHIFTER_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             out_last
);

  localparam int CW   = cnt_width(WIDTH);
  localparam int OBIT = MSB_FIRST ? WIDTH - 1 : 0;

  shift_state_t     state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt;
  logic             term, clear, inc, accept;
  logic             out_nxt, last_nxt;

  piso_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (inc),
    .count (cnt),
    .term  (term)
  );

`ifdef PISO_PARITY_EN
  logic par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      par <= 1'b0;
    else if (accept)
      par <= ^in_data;
  end
`endif

  // in_ready depends only on state and counter; accept then overrides the normal next state.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    clear     = 1'b0;
    inc       = 1'b0;
    in_ready  = 1'b0;
    out_nxt   = 1'b0;
    last_nxt  = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      SHIFT: begin
        sreg_nxt = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
        if (!term) begin
          inc = 1'b1;
        end else begin
          clear = 1'b1;
`ifdef PISO_PARITY_EN
          state_nxt = PARITY;
`else
          in_ready  = 1'b1;
          state_nxt = IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        in_ready  = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase

    accept = in_ready && in_valid;
    if (accept) begin
      sreg_nxt  = in_data;
      clear     = 1'b1;
      inc       = 1'b0;
      state_nxt = SHIFT;
    end

    // Outputs are precomputed from next state so they can be driven straight from flops.
    if (state_nxt == SHIFT) begin
      out_nxt = sreg_nxt[OBIT];
`ifndef PISO_PARITY_EN
      last_nxt = inc && (cnt == CW'(WIDTH - 2));
`endif
    end
`ifdef PISO_PARITY_EN
    else if (state_nxt == PARITY) begin
      out_nxt  = par;
      last_nxt = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      sreg      <= sreg_nxt;
      out       <= out_nxt;
      out_valid <= (state_nxt != IDLE);
      out_last  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_piso_shifter.sv
// Table-driven bench for piso_shifter: MSB-first and LSB-first instances share one input stream.
// Expectations follow the PISO_PARITY_EN build setting.
module tb_piso_shifter;
  import shifter_pkg::*;

  localparam int W = SHIFTER_WIDTH;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         m_ready, m_out, m_valid, m_last;
  logic         l_ready, l_out, l_valid, l_last;
  logic [2:0]   sipo;
  int           checks = 0;
  int           failures = 0;

  typedef struct {
    logic         valid;
    logic [W-1:0] data;
    logic         e_m_out;
    logic         e_l_out;
    logic         e_valid;
    logic         e_last;
    logic         e_ready;
    logic         chk_sipo;
    logic [2:0]   e_sipo;
  } vec_t;

  vec_t tbl[$];

  piso_shifter #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(m_ready),
    .out(m_out), .out_valid(m_valid), .out_last(m_last)
  );

  piso_shifter #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(l_ready),
    .out(l_out), .out_valid(l_valid), .out_last(l_last)
  );

  always #5 clk = ~clk;

  // Stand-in for the 3-bit SIPO receiver on the MSB-first stream.
  always @(posedge clk or posedge rst) begin
    if (rst)
      sipo <= 3'b000;
    else if (m_valid)
      sipo <= {sipo[1:0], m_out};
  end

  task automatic checkOutput(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s[%0d] got=%b expected=%b", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid = v.valid;
    in_data  = v.data;
  endtask

  task automatic addVec(input logic v, input logic [W-1:0] d, input logic mo, input logic lo,
                        input logic ev, input logic el, input logic er);
    vec_t t;
    t.valid = v;  t.data = d;  t.e_m_out = mo;  t.e_l_out = lo;
    t.e_valid = ev;  t.e_last = el;  t.e_ready = er;  t.chk_sipo = 1'b0;  t.e_sipo = 3'b000;
    tbl.push_back(t);
  endtask

  task automatic addIdle(input logic v, input logic [W-1:0] d);
    addVec(v, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // mseq/lseq list the expected bits in time order, first bit in position 7.
  task automatic addData(input logic [7:0] mseq, input logic [7:0] lseq,
                         input logic nv, input logic [W-1:0] nd,
                         input logic lv, input logic [W-1:0] ld);
    for (int k = 1; k <= 8; k++) begin
      if (k < 8)
        addVec(nv, nd, mseq[8-k], lseq[8-k], 1'b1, 1'b0, 1'b0);
      else
        addVec(lv, ld, mseq[0], lseq[0], 1'b1, !PAR, !PAR);
    end
  endtask

  task automatic addParity(input logic p, input logic v, input logic [W-1:0] d);
    addVec(v, d, p, p, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic runTable(input string name);
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkOutput({name, ".m_out"},   i, {2'b0, m_out},   {2'b0, tbl[i].e_m_out});
      checkOutput({name, ".l_out"},   i, {2'b0, l_out},   {2'b0, tbl[i].e_l_out});
      checkOutput({name, ".m_valid"}, i, {2'b0, m_valid}, {2'b0, tbl[i].e_valid});
      checkOutput({name, ".l_valid"}, i, {2'b0, l_valid}, {2'b0, tbl[i].e_valid});
      checkOutput({name, ".m_last"},  i, {2'b0, m_last},  {2'b0, tbl[i].e_last});
      checkOutput({name, ".l_last"},  i, {2'b0, l_last},  {2'b0, tbl[i].e_last});
      checkOutput({name, ".m_ready"}, i, {2'b0, m_ready}, {2'b0, tbl[i].e_ready});
      checkOutput({name, ".l_ready"}, i, {2'b0, l_ready}, {2'b0, tbl[i].e_ready});
      if (tbl[i].chk_sipo)
        checkOutput({name, ".sipo"}, i, sipo, tbl[i].e_sipo);
      @(posedge clk);
      #1;
    end
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    #12;
    checkOutput("reset.m_out",   0, {2'b0, m_out},   3'b000);
    checkOutput("reset.m_valid", 0, {2'b0, m_valid}, 3'b000);
    checkOutput("reset.m_last",  0, {2'b0, m_last},  3'b000);
    checkOutput("reset.m_ready", 0, {2'b0, m_ready}, 3'b001);
    checkOutput("reset.l_valid", 0, {2'b0, l_valid}, 3'b000);
    checkOutput("reset.l_ready", 0, {2'b0, l_ready}, 3'b001);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // A5 with junk held on the inputs mid-frame, then a second word for ordering.
    addIdle(1'b1, 8'hA5);
    if (PAR) begin
      addData(8'b10100101, 8'b10100101, 1'b1, 8'h3C, 1'b1, 8'h3C);
      addParity(1'b0, 1'b1, 8'h07);
      addData(8'b00000111, 8'b11100000, 1'b0, 8'h00, 1'b0, 8'h00);
      addParity(1'b1, 1'b0, 8'h00);
      addIdle(1'b0, 8'h00);
    end else begin
      addData(8'b10100101, 8'b10100101, 1'b1, 8'h3C, 1'b0, 8'h00);
      addIdle(1'b1, 8'h01);
      addData(8'b00000001, 8'b10000000, 1'b0, 8'h00, 1'b0, 8'h00);
      addIdle(1'b0, 8'h00);
    end
    runTable("single");

    // Back-to-back FF then 00 with in_valid held high, observed through the SIPO stand-in.
    if (!PAR) begin
      addIdle(1'b1, 8'hFF);
      addData(8'hFF, 8'hFF, 1'b1, 8'h5A, 1'b1, 8'h00);
      addData(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00);
      addIdle(1'b0, 8'h00);
      tbl[9].chk_sipo = 1'b1;
      tbl[9].e_sipo = 3'b111;
      tbl[12].chk_sipo = 1'b1;
      tbl[12].e_sipo = 3'b000;
      runTable("b2b");
    end

    // Reset in the middle of a 3C frame, then a clean 81 frame.
    in_valid = 1'b1;
    in_data = 8'h3C;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 8'hFF;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("abort.pre_m_valid", 4, {2'b0, m_valid}, 3'b001);
    checkOutput("abort.pre_m_out",   4, {2'b0, m_out},   3'b001);
    checkOutput("abort.pre_l_out",   4, {2'b0, l_out},   3'b001);
    rst = 1'b1;
    #1;
    checkOutput("abort.m_valid", 4, {2'b0, m_valid}, 3'b000);
    checkOutput("abort.m_ready", 4, {2'b0, m_ready}, 3'b001);
    checkOutput("abort.m_out",   4, {2'b0, m_out},   3'b000);
    checkOutput("abort.l_valid", 4, {2'b0, l_valid}, 3'b000);
    checkOutput("abort.l_ready", 4, {2'b0, l_ready}, 3'b001);
    @(posedge clk);
    #1;
    rst = 1'b0;
    addIdle(1'b1, 8'h81);
    addData(8'b10000001, 8'b10000001, 1'b0, 8'h00, 1'b0, 8'h00);
    if (PAR)
      addParity(1'b0, 1'b0, 8'h00);
    addIdle(1'b0, 8'h00);
    runTable("recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_shifter.md
Name: piso_shifter

Overview:
- Parallel-in, serial-out shifter; the transmit end of the serial bit stream that the SIPO shifter deserializes.
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock with a valid flag and a last-bit marker.
- Back-to-back words are supported with no idle gap.
- Sits between a word-level producer and any serial consumer, e.g. the 3-bit SIPO shifter.

Parameters:
- WIDTH, 8: bits per word; legal range ≥2.
- MSB_FIRST, 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  parallel word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  shifter can accept a word this cycle.
- out  output  1  serial data bit.
- out_valid  output  1  out carries a valid bit this cycle.
- out_last  output  1  this is the final bit of the current frame.

Behaviour:
- Reset (async assert, released synchronously at the next clk edge):
  - state=IDLE, shift register=0, bit counter=0.
  - out=0, out_valid=0, out_last=0, in_ready=1.
- States: IDLE, SHIFT (plus PARITY when the optional feature is enabled).
- Accept: a word is taken on a rising edge with in_valid && in_ready. in_data is not sampled at any other time.
- Latency: the first bit appears on out, with out_valid=1, in the cycle after the accept edge.
- IDLE:
  - in_ready=1, out_valid=0, out=0.
  - On accept: load the shift register, counter=0, go to SHIFT.
- SHIFT:
  - out = sreg[WIDTH-1] if MSB_FIRST, else sreg[0]; out_valid=1.
  - Each cycle, shift by one toward the output end (zero fill) and increment the counter.
  - out_last=1 when counter==WIDTH-1 (no parity).
- Last-bit cycle (counter==WIDTH-1, no parity):
  - in_ready=1 so the next word can load without a gap.
  - Accept in this cycle: reload, counter=0, stay in SHIFT.
  - No accept: go to IDLE.
- In SHIFT with counter<WIDTH-1: in_ready=0. in_valid is ignored and in_data may change freely without corrupting the frame.
- Outputs out, out_valid and out_last are registered; in_ready is combinational from state and counter only, with no path from in_valid.
- Counter width is $clog2(WIDTH+1). It never exceeds WIDTH.
- Reset asserted mid-frame aborts the frame immediately: out_valid drops asynchronously and no partial word resumes.
- A frame always runs to completion; there is no stall input.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the accepted word) is captured at accept.
  - After the WIDTH data bits, the PARITY state emits that bit with out_valid=1 and out_last=1.
  - out_last is therefore not asserted on the last data bit.
  - in_ready=1 only in the PARITY cycle (and in IDLE). An accept there goes to SHIFT; otherwise go to IDLE.
  - Frame length is WIDTH+1 cycles.
- Undefined: the PARITY state and parity logic are absent; frame length is WIDTH cycles.

Decomposition:
- shifter_pkg holds:
  - the state enum typedef (IDLE, SHIFT, PARITY);
  - a function computing the counter width;
  - the default WIDTH constant, shared with the SIPO shifter.
- One natural sub-module, piso_bit_cnt: a counter with clear, increment and terminal flag (count==WIDTH-1).
- The FSM and shift register stay in piso_shifter.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, accept 8'hA5 once:
   - out = 1,0,1,0,0,1,0,1 over cycles 1–8 after accept, out_valid=1 throughout;
   - out_last=1 only in cycle 8;
   - cycle 9: out_valid=0, in_ready=1.
2. MSB_FIRST=0, accept 8'hA5:
   - out = 1,0,1,0,0,1,0,1 (palindrome), which confirms ordering only with a second word;
   - accept 8'h01 → out = 1,0,0,0,0,0,0,0.
3. Back-to-back, in_valid held high with 8'hFF then 8'h00:
   - 16 consecutive out_valid cycles, out = eight 1s then eight 0s;
   - out_last in cycles 8 and 16; in_ready high only in cycles 0, 8 and 16.
4. Chain out into the 3-bit SIPO (its in port):
   - after the 8'hFF frame, SIPO out==3'b111;
   - after 8'h00 plus three bit times, SIPO out==3'b000.
5. Accept 8'h3C, assert rst at bit 4:
   - out_valid=0 and in_ready=1 immediately;
   - after release, accept 8'h81 → clean frame 1,0,0,0,0,0,0,1.
6. With PISO_PARITY_EN:
   - 8'hA5 (four ones) → 9-bit frame ending with parity 0 and out_last in cycle 9;
   - 8'h07 → parity bit 1;
   - in_ready=0 in cycle 8.
